// File: rtl/xalu_pkg.sv
// Shared definitions for the nibble-serial XALU sequencer.
// Holds the slice op codes, the FSM state type and the index-width helper.
package xalu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_AND   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_XOR   = 3'd3;
    localparam logic [2:0] ALU_PASSA = 3'd4;
    localparam logic [2:0] ALU_PASSB = 3'd5;
    localparam logic [2:0] ALU_SHR   = 3'd6;
    localparam logic [2:0] ALU_SHL   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xalu_nibble_mux.sv
// Picks operand nibble idx out of the wide A/B words.
// B may be inverted on the way out for subtraction.
module xalu_nibble_mux
    import xalu_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int IW      = idx_w(NIBBLES)
) (
    input  logic [4*NIBBLES-1:0] a_i,
    input  logic [4*NIBBLES-1:0] b_i,
    input  logic [IW-1:0]        idx_i,
    input  logic                 inv_b_i,
    output logic [3:0]           a_nib_o,
    output logic [3:0]           b_nib_o
);

    logic [3:0] b_sel;

    // Select the addressed nibble of each operand.
    always_comb begin
        a_nib_o = 4'h0;
        b_sel   = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_i == IW'(i)) begin
                a_nib_o = a_i[4*i +: 4];
                b_sel   = b_i[4*i +: 4];
            end
        end
        b_nib_o = inv_b_i ? ~b_sel : b_sel;
    end

endmodule

// File: rtl/xalu_nibble_sequencer.sv
// Drives one 4-bit XALU slice across a 4*NIBBLES-bit operation.
// Optional subtract support is enabled by defining XALU_SEQ_SUB_EN.
module xalu_nibble_sequencer
    import xalu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic                 req_cin,
    input  logic                 req_com,
    input  logic                 req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_result,
    output logic                 rsp_cout,
    output logic                 rsp_zero,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_f,
    output logic                 alu_ci_left,
    output logic                 alu_ci_right,
    output logic                 alu_com,
    input  logic [3:0]           alu_d,
    input  logic                 alu_co_left,
    input  logic                 alu_co_right
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = idx_w(NIBBLES);

    state_t         state_q, state_d;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   result_q, result_d;
    logic           com_q, sub_q, carry_q;
    logic [IW-1:0]  idx_q;
    logic           cout_q, zero_q;

    logic           is_shr, has_carry, last, carry_nxt, sub_acc;
    logic [3:0]     a_nib, b_nib;

`ifdef XALU_SEQ_SUB_EN
    assign sub_acc = req_sub && (req_op == ALU_ADD);
`else
    logic unused_sub;
    assign unused_sub = req_sub;
    assign sub_acc    = 1'b0;
`endif

    assign is_shr    = (op_q == ALU_SHR);
    assign has_carry = (op_q == ALU_ADD) || (op_q == ALU_SHL) || is_shr;
    assign last      = is_shr ? (idx_q == '0) : (idx_q == IW'(NIBBLES - 1));
    assign carry_nxt = is_shr ? alu_co_right : alu_co_left;

    assign rsp_valid  = (state_q == DONE);
    assign rsp_result = result_q;
    assign rsp_cout   = cout_q;
    assign rsp_zero   = zero_q;

    xalu_nibble_mux #(
        .NIBBLES (NIBBLES),
        .IW      (IW)
    ) u_mux (
        .a_i     (a_q),
        .b_i     (b_q),
        .idx_i   (idx_q),
        .inv_b_i (sub_q),
        .a_nib_o (a_nib),
        .b_nib_o (b_nib)
    );

    // Merge the slice result into the addressed nibble of the result word.
    always_comb begin
        result_d = result_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                result_d[4*i +: 4] = alu_d;
            end
        end
    end

    // Next state, handshake and slice drive; slice inputs idle at 0 outside RUN.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        alu_a        = 4'h0;
        alu_b        = 4'h0;
        alu_f        = 3'd0;
        alu_ci_left  = 1'b0;
        alu_ci_right = 1'b0;
        alu_com      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = RUN;
            end
            RUN: begin
                alu_a        = a_nib;
                alu_b        = b_nib;
                alu_f        = op_q;
                alu_com      = com_q;
                alu_ci_left  = is_shr ? carry_q : 1'b0;
                alu_ci_right = is_shr ? 1'b0 : carry_q;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch requests, step through nibbles and capture the final response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            com_q    <= 1'b0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                op_q    <= req_op;
                a_q     <= req_a;
                b_q     <= req_b;
                com_q   <= req_com;
                sub_q   <= sub_acc;
                carry_q <= sub_acc ? 1'b1 : req_cin;
                idx_q   <= (req_op == ALU_SHR) ? IW'(NIBBLES - 1) : '0;
            end else if (state_q == RUN) begin
                result_q <= result_d;
                carry_q  <= carry_nxt;
                idx_q    <= is_shr ? idx_q - 1'b1 : idx_q + 1'b1;
                if (last) begin
                    zero_q <= (result_d == '0);
                    cout_q <= has_carry ? carry_nxt : 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xalu_nibble_sequencer.sv
// Directed bench for xalu_nibble_sequencer with a behavioural 4-bit slice.
// Subtract vectors run only when XALU_SEQ_SUB_EN is defined.
module tb_xalu_nibble_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic         req_cin, req_com, req_sub;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_cout, rsp_zero;
    logic [3:0]   alu_a, alu_b, alu_d;
    logic [2:0]   alu_f;
    logic         alu_ci_left, alu_ci_right, alu_com;
    logic         alu_co_left, alu_co_right;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xalu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .req_com      (req_com),
        .req_sub      (req_sub),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_cout     (rsp_cout),
        .rsp_zero     (rsp_zero),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_f        (alu_f),
        .alu_ci_left  (alu_ci_left),
        .alu_ci_right (alu_ci_right),
        .alu_com      (alu_com),
        .alu_d        (alu_d),
        .alu_co_left  (alu_co_left),
        .alu_co_right (alu_co_right)
    );

    // Behavioural model of the 4-bit slice.
    logic [4:0] sum;
    logic [3:0] raw;
    always_comb begin
        sum          = 5'd0;
        raw          = 4'h0;
        alu_co_left  = 1'b0;
        alu_co_right = 1'b0;
        case (alu_f)
            3'd0: begin
                sum         = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci_right};
                raw         = sum[3:0];
                alu_co_left = sum[4];
            end
            3'd1: raw = alu_a & alu_b;
            3'd2: raw = alu_a | alu_b;
            3'd3: raw = alu_a ^ alu_b;
            3'd4: raw = alu_a;
            3'd5: raw = alu_b;
            3'd6: begin
                raw          = {alu_ci_left, alu_a[3:1]};
                alu_co_right = alu_a[0];
            end
            default: begin
                raw         = {alu_a[2:0], alu_ci_right};
                alu_co_left = alu_a[3];
            end
        endcase
        alu_d = alu_com ? ~raw : raw;
    end

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input logic com, input logic sub,
                          output int lat);
        @(negedge clk);
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_com   = com;
        req_sub   = sub;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 16'h5A5A;
        req_b     = 16'hC3C3;
        req_cin   = ~cin;
        lat       = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        checks++;
        if (rsp_result !== 16'h0 || rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp res=%h cout=%b zero=%b want 0 0 0",
                     rsp_result, rsp_cout, rsp_zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_f, alu_ci_left, alu_ci_right, alu_com} !== 17'h0) begin
            errors++;
            $display("FAIL reset_alu a=%h b=%h f=%0d want 0", alu_a, alu_b, alu_f);
        end
    endtask

    task automatic test_add();
        int lat;
        run_op(3'd0, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL add1_latency got %0d want 4", lat);
        end
        checks++;
        if (rsp_result !== 16'h1000 || rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL add1 res=%h cout=%b zero=%b want 1000 0 0",
                     rsp_result, rsp_cout, rsp_zero);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_ready got %b want 0", req_ready);
        end
        release_rsp();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 16'h0000 ||
                rsp_cout !== 1'b1 || rsp_zero !== 1'b1) begin
                errors++;
                $display("FAIL add2_hold%0d v=%b res=%h cout=%b zero=%b want 1 0000 1 1",
                         k, rsp_valid, rsp_result, rsp_cout, rsp_zero);
            end
            @(posedge clk);
            #1;
        end
        release_rsp();
    endtask

    task automatic test_shift();
        int lat;
        run_op(3'd6, 16'h8001, 16'h0000, 1'b1, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4 || rsp_result !== 16'hC000 || rsp_cout !== 1'b1) begin
            errors++;
            $display("FAIL shr lat=%0d res=%h cout=%b want 4 c000 1",
                     lat, rsp_result, rsp_cout);
        end
        release_rsp();
        run_op(3'd7, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4 || rsp_result !== 16'h0002 || rsp_cout !== 1'b1) begin
            errors++;
            $display("FAIL shl lat=%0d res=%h cout=%b want 4 0002 1",
                     lat, rsp_result, rsp_cout);
        end
        release_rsp();
    endtask

    task automatic test_logic();
        int lat;
        run_op(3'd3, 16'hA5A5, 16'hA5A5, 1'b1, 1'b1, 1'b0, lat);
        checks++;
        if (rsp_result !== 16'hFFFF || rsp_zero !== 1'b0 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL xor_com res=%h zero=%b cout=%b want ffff 0 0",
                     rsp_result, rsp_zero, rsp_cout);
        end
        release_rsp();
        run_op(3'd1, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (rsp_result !== 16'h00F0 || rsp_zero !== 1'b0 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL and res=%h zero=%b cout=%b want 00f0 0 0",
                     rsp_result, rsp_zero, rsp_cout);
        end
        release_rsp();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        req_op    = 3'd0;
        req_a     = 16'h1234;
        req_b     = 16'h1111;
        req_cin   = 1'b0;
        req_com   = 1'b0;
        req_sub   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (alu_a !== 4'h4 || alu_b !== 4'h1 || alu_f !== 3'd0 || alu_ci_right !== 1'b0) begin
            errors++;
            $display("FAIL run_drive a=%h b=%h f=%0d ci=%b want 4 1 0 0",
                     alu_a, alu_b, alu_f, alu_ci_right);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 4'h0 ||
            rsp_result !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset ready=%b valid=%b alu_a=%h res=%h want 1 0 0 0",
                     req_ready, rsp_valid, alu_a, rsp_result);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4 || rsp_result !== 16'h2345 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL add_after_rst lat=%0d res=%h cout=%b want 4 2345 0",
                     lat, rsp_result, rsp_cout);
        end
        release_rsp();
    endtask

    task automatic test_sub();
        int lat;
`ifdef XALU_SEQ_SUB_EN
        run_op(3'd0, 16'h0005, 16'h0007, 1'b0, 1'b0, 1'b1, lat);
        checks++;
        if (rsp_result !== 16'hFFFE || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL sub1 res=%h cout=%b want fffe 0", rsp_result, rsp_cout);
        end
        release_rsp();
        run_op(3'd0, 16'h0007, 16'h0005, 1'b0, 1'b0, 1'b1, lat);
        checks++;
        if (rsp_result !== 16'h0002 || rsp_cout !== 1'b1) begin
            errors++;
            $display("FAIL sub2 res=%h cout=%b want 0002 1", rsp_result, rsp_cout);
        end
        release_rsp();
`else
        run_op(3'd0, 16'h0005, 16'h0007, 1'b0, 1'b0, 1'b1, lat);
        checks++;
        if (rsp_result !== 16'h000C || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL sub_ignored res=%h cout=%b want 000c 0", rsp_result, rsp_cout);
        end
        release_rsp();
`endif
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_com   = 1'b0;
        req_sub   = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_add();
        test_shift();
        test_logic();
        test_reset_mid_run();
        test_sub();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
